// File: rtl/instr_encode_writer.sv
// RV32I instruction encoder and sequential instruction-memory writer.
// Boot/test loader: one-hot type flags plus fields in, encoded words out.
module instr_encode_writer #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              r,
    input  logic              load,
    input  logic              store,
    input  logic              branch,
    input  logic              itype,
    input  logic              jalr,
    input  logic              jal,
    input  logic              lui,
    input  logic              auipc,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    typedef enum logic {
        S_IDLE,
        S_WRITE
    } state_t;

    localparam logic [ADDR_W-1:0] LP_BASE = ADDR_W'(BASE_ADDR);

    state_t            r_state;
    logic              r_we;
    logic [31:0]       r_wdata;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_count;
    logic              r_err;

    logic [8:0]        w_flags;
    logic              w_onehot;
    logic              w_full;
    logic              w_xfer;
    logic              w_shift;
    logic [31:0]       w_word;

    assign w_flags  = {r, load, store, branch, itype, jalr, jal, lui, auipc};
    assign w_onehot = $onehot(w_flags);
    // count never exceeds 2**ADDR_W, so its top bit is the full flag
    assign w_full   = r_count[ADDR_W];
    assign w_xfer   = in_valid & in_ready;
    assign w_shift  = (funct3 == 3'b001) | (funct3 == 3'b101);

    assign in_ready  = (r_state == S_IDLE) & ~w_full & ~rst;
    // a reset arriving during WRITE drops the pending write
    assign mem_we    = r_we & ~rst;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign count     = r_count;
    assign full      = w_full;
    assign err       = r_err;

    // Build the 32-bit word for whichever single type flag is set
    always_comb begin
        w_word = 32'h0;
        case (1'b1)
            r: w_word = {funct7, rs2, rs1, funct3, rd, 7'b0110011};
            itype: begin
                if (w_shift)
                    w_word = {funct7, imm[4:0], rs1, funct3, rd, 7'b0010011};
                else
                    w_word = {imm[11:0], rs1, funct3, rd, 7'b0010011};
            end
            load: w_word = {imm[11:0], rs1, funct3, rd, 7'b0000011};
            jalr: w_word = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
            store: w_word = {imm[11:5], rs2, rs1, funct3, imm[4:0],
                             7'b0100011};
            branch: w_word = {imm[12], imm[10:5], rs2, rs1, funct3,
                              imm[4:1], imm[11], 7'b1100011};
            lui: w_word = {imm[31:12], rd, 7'b0110111};
            auipc: w_word = {imm[31:12], rd, 7'b0010111};
            jal: w_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd,
                           7'b1101111};
            default: w_word = 32'h0;
        endcase
    end

    // Loader FSM: accept in IDLE, strobe one write in WRITE, then advance
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_wdata <= 32'h0;
            r_addr  <= LP_BASE;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_xfer) begin
                        if (w_onehot) begin
                            r_wdata <= w_word;
                            r_we    <= 1'b1;
                            r_state <= S_WRITE;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    r_we    <= 1'b0;
                    r_addr  <= r_addr + 1'b1;
                    r_count <= r_count + 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encode_writer.sv
// Self-checking bench for instr_encode_writer.
// Scoreboard queues hold expected {addr,word} pairs popped by write monitors.
module tb_instr_encode_writer;

    localparam logic [8:0] F_R   = 9'h100;
    localparam logic [8:0] F_LD  = 9'h080;
    localparam logic [8:0] F_ST  = 9'h040;
    localparam logic [8:0] F_BR  = 9'h020;
    localparam logic [8:0] F_I   = 9'h010;
    localparam logic [8:0] F_JR  = 9'h008;
    localparam logic [8:0] F_JAL = 9'h004;
    localparam logic [8:0] F_LUI = 9'h002;
    localparam logic [8:0] F_AUI = 9'h001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vld_a = 1'b0;
    logic        vld_b = 1'b0;
    logic [8:0]  fl = '0;
    logic [4:0]  rd_s = '0, rs1_s = '0, rs2_s = '0;
    logic [2:0]  f3_s = '0;
    logic [6:0]  f7_s = '0;
    logic [31:0] imm_s = '0;

    logic        rdy_a, we_a, full_a, err_a;
    logic [7:0]  addr_a;
    logic [31:0] wd_a;
    logic [8:0]  cnt_a;
    logic        rdy_b, we_b, full_b, err_b;
    logic [1:0]  addr_b;
    logic [31:0] wd_b;
    logic [2:0]  cnt_b;

    int errors = 0;
    int checks = 0;
    logic [39:0] q_a[$];
    logic [39:0] q_b[$];
    int a_addr = 0, a_cnt = 0;
    int b_addr = 0, b_cnt = 0;

    always #5 clk = ~clk;

    instr_encode_writer #(.ADDR_W(8), .BASE_ADDR(0)) dut_a (
        .clk(clk), .rst(rst), .in_valid(vld_a), .in_ready(rdy_a),
        .r(fl[8]), .load(fl[7]), .store(fl[6]), .branch(fl[5]),
        .itype(fl[4]), .jalr(fl[3]), .jal(fl[2]), .lui(fl[1]),
        .auipc(fl[0]), .rd(rd_s), .rs1(rs1_s), .rs2(rs2_s),
        .funct3(f3_s), .funct7(f7_s), .imm(imm_s),
        .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wd_a),
        .count(cnt_a), .full(full_a), .err(err_a)
    );

    instr_encode_writer #(.ADDR_W(2), .BASE_ADDR(0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(vld_b), .in_ready(rdy_b),
        .r(fl[8]), .load(fl[7]), .store(fl[6]), .branch(fl[5]),
        .itype(fl[4]), .jalr(fl[3]), .jal(fl[2]), .lui(fl[1]),
        .auipc(fl[0]), .rd(rd_s), .rs1(rs1_s), .rs2(rs2_s),
        .funct3(f3_s), .funct7(f7_s), .imm(imm_s),
        .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wd_b),
        .count(cnt_b), .full(full_b), .err(err_b)
    );

    // Write monitors: every strobe must match the oldest expected entry
    always @(negedge clk) begin
        if (we_a) begin
            checks++;
            if (q_a.size() == 0) begin
                errors++;
                $display("FAIL wr_a_unexpected addr=%0d data=%h", addr_a, wd_a);
            end else begin
                logic [39:0] e;
                e = q_a.pop_front();
                if ({addr_a, wd_a} !== e) begin
                    errors++;
                    $display("FAIL wr_a got addr=%0d data=%h exp addr=%0d data=%h",
                             addr_a, wd_a, e[39:32], e[31:0]);
                end
            end
        end
        if (we_b) begin
            checks++;
            if (q_b.size() == 0) begin
                errors++;
                $display("FAIL wr_b_unexpected addr=%0d data=%h", addr_b, wd_b);
            end else begin
                logic [39:0] e;
                e = q_b.pop_front();
                if ({6'd0, addr_b, wd_b} !== e) begin
                    errors++;
                    $display("FAIL wr_b got addr=%0d data=%h exp addr=%0d data=%h",
                             addr_b, wd_b, e[39:32], e[31:0]);
                end
            end
        end
    end

    task automatic send(input bit b, input logic [8:0] f,
                        input logic [4:0] rd_i, input logic [4:0] rs1_i,
                        input logic [4:0] rs2_i, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] im,
                        input bit exp_wr, input logic [31:0] exp_w);
        int n;
        n = 0;
        @(negedge clk);
        while (!(b ? rdy_b : rdy_a) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout inst=%0d", b);
            return;
        end
        fl = f; rd_s = rd_i; rs1_s = rs1_i; rs2_s = rs2_i;
        f3_s = f3; f7_s = f7; imm_s = im;
        if (b) vld_b = 1'b1;
        else vld_a = 1'b1;
        if (exp_wr) begin
            if (b) begin
                q_b.push_back({6'd0, 2'(b_addr), exp_w});
                b_addr = (b_addr + 1) % 4;
                b_cnt++;
            end else begin
                q_a.push_back({8'(a_addr), exp_w});
                a_addr = (a_addr + 1) % 256;
                a_cnt++;
            end
        end
        @(posedge clk);
        #1;
        vld_a = 1'b0;
        vld_b = 1'b0;
        fl = '0;
        checks++;
        if ((b ? rdy_b : rdy_a) !== !exp_wr) begin
            errors++;
            $display("FAIL ready_after_accept got=%b exp=%b",
                     b ? rdy_b : rdy_a, !exp_wr);
        end
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
        checks++;
        if (cnt_a !== 9'(a_cnt) || addr_a !== 8'(a_addr)) begin
            errors++;
            $display("FAIL count_a got cnt=%0d addr=%0d exp cnt=%0d addr=%0d",
                     cnt_a, addr_a, a_cnt, a_addr);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (rdy_a !== 1'b0 || we_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_cycle rdy=%b we=%b exp 0 0", rdy_a, we_a);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({rdy_a, we_a, wd_a, addr_a, cnt_a, full_a, err_a} !==
            {1'b1, 1'b0, 32'h0, 8'h0, 9'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state rdy=%b we=%b wd=%h addr=%0d cnt=%0d full=%b err=%b",
                     rdy_a, we_a, wd_a, addr_a, cnt_a, full_a, err_a);
        end
    endtask

    task automatic test_addi();
        send(0, F_I, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1, 32'h00500093);
        settle();
    endtask

    task automatic test_back_to_back();
        send(0, F_R, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1, 32'h002081B3);
        send(0, F_ST, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1, 32'h0020A423);
        settle();
    endtask

    task automatic test_formats();
        send(0, F_BR, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC, 1, 32'hFE208EE3);
        send(0, F_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 1, 32'h008000EF);
        send(0, F_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1, 32'h123452B7);
        send(0, F_LD, 5'd5, 5'd2, 5'd0, 3'd2, 7'd0, 32'hFFFFFFFC, 1, 32'hFFC12283);
        send(0, F_I, 5'd1, 5'd1, 5'd0, 3'd1, 7'd0, 32'd3, 1, 32'h00309093);
        send(0, F_I, 5'd2, 5'd2, 5'd0, 3'd5, 7'h20, 32'd4, 1, 32'h40415113);
        send(0, F_JR, 5'd0, 5'd1, 5'd0, 3'd7, 7'd0, 32'd0, 1, 32'h00008067);
        send(0, F_AUI, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00001000, 1, 32'h00001197);
        settle();
    endtask

    task automatic test_invalid();
        send(0, 9'h000, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 0, 32'h0);
        @(negedge clk);
        checks++;
        if (err_a !== 1'b1) begin
            errors++;
            $display("FAIL err_none got=%b exp=1", err_a);
        end
        send(0, F_R | F_LD, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 0, 32'h0);
        settle();
        send(0, F_I, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1, 32'h00500093);
        settle();
        checks++;
        if (err_a !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky got=%b exp=1", err_a);
        end
    endtask

    task automatic test_full();
        for (int k = 0; k < 4; k++)
            send(1, F_I, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'(k + 1), 1,
                 32'h00000093 | (32'(k + 1) << 20));
        repeat (2) @(negedge clk);
        checks++;
        if ({full_b, rdy_b, addr_b, cnt_b} !== {1'b1, 1'b0, 2'd0, 3'd4}) begin
            errors++;
            $display("FAIL full_b full=%b rdy=%b addr=%0d cnt=%0d exp 1 0 0 4",
                     full_b, rdy_b, addr_b, cnt_b);
        end
        fl = F_I;
        vld_b = 1'b1;
        repeat (4) @(negedge clk);
        vld_b = 1'b0;
        fl = '0;
        checks++;
        if (cnt_b !== 3'd4 || full_b !== 1'b1 || err_b !== 1'b0) begin
            errors++;
            $display("FAIL full_ignore cnt=%0d full=%b err=%b exp 4 1 0",
                     cnt_b, full_b, err_b);
        end
    endtask

    task automatic test_reset_in_write();
        int n;
        n = 0;
        @(negedge clk);
        while (!rdy_a && n < 20) begin
            @(negedge clk);
            n++;
        end
        fl = F_I; rd_s = 5'd1; rs1_s = 5'd0; f3_s = 3'd0; imm_s = 32'd7;
        vld_a = 1'b1;
        @(posedge clk);
        #1;
        vld_a = 1'b0;
        fl = '0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (we_a !== 1'b0) begin
            errors++;
            $display("FAIL rst_write_we got=%b exp=0", we_a);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        a_addr = 0;
        a_cnt = 0;
        b_addr = 0;
        b_cnt = 0;
        @(negedge clk);
        checks++;
        if ({we_a, cnt_a, addr_a, err_a, rdy_a, wd_a} !==
            {1'b0, 9'd0, 8'd0, 1'b0, 1'b1, 32'h0}) begin
            errors++;
            $display("FAIL rst_write_state we=%b cnt=%0d addr=%0d err=%b rdy=%b wd=%h",
                     we_a, cnt_a, addr_a, err_a, rdy_a, wd_a);
        end
        send(0, F_I, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1, 32'h00500093);
        settle();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_formats();
        test_invalid();
        test_full();
        test_reset_in_write();
        repeat (2) @(negedge clk);
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            errors++;
            $display("FAIL missing_writes pending_a=%0d pending_b=%0d exp 0 0",
                     q_a.size(), q_b.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
